// File: rtl/hs_fifo_afifo_wr_arb_if.sv
// Requester-side and FIFO-write-side signal bundle for the packet write arbiter.
interface hs_fifo_afifo_wr_arb_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_drop;
  logic [N_REQ-1:0]            req_en;
  logic                        wvalid;
  logic                        wready;
  logic [DATA_WIDTH-1:0]       wdata;
  logic                        wlast;
  logic                        wdrop;
  logic                        walmost_full;
  logic                        busy;
  logic [ID_WIDTH-1:0]         grant_id;
  logic [15:0]                 pkt_cnt;

  modport master (
    input  req_valid, req_data, req_last, req_drop, req_en, wready, walmost_full,
    output req_ready, wvalid, wdata, wlast, wdrop, busy, grant_id, pkt_cnt
  );

  modport slave (
    output req_valid, req_data, req_last, req_drop, req_en, wready, walmost_full,
    input  req_ready, wvalid, wdata, wlast, wdrop, busy, grant_id, pkt_cnt
  );
endinterface

// File: rtl/hs_fifo_afifo_wr_arb.sv
// Packet-granular round-robin arbiter feeding the single hs_fifo_afifo write port;
// a grant is held from the first beat until the last beat is accepted.
module hs_fifo_afifo_wr_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
  input logic                    src_clk,
  input logic                    src_srst,
  hs_fifo_afifo_wr_arb_if.master bus
);
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [N_REQ-1:0]      elig;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  sel_found;
  logic                  start_pkt;
  logic                  last_acc;
  logic [DATA_WIDTH-1:0] data_sel;

  assign elig = bus.req_valid & bus.req_en;

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_WIDTH'((32'(rr_q) + k) % N_REQ);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_WIDTH'(k) == grant_q) begin
        data_sel = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign start_pkt = (state_q == ST_IDLE) && sel_found && !bus.walmost_full;
  assign last_acc  = (state_q == ST_BUSY) && bus.req_valid[grant_q] && bus.wready
                     && bus.req_last[grant_q];

  // State register.
  always_ff @(posedge src_clk) begin
    if (src_srst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_pkt) state_d = ST_BUSY;
      ST_BUSY: if (last_acc)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: pass-through of the locked requester while busy, all low when idle.
  always_comb begin
    bus.wvalid    = 1'b0;
    bus.wdata     = '0;
    bus.wlast     = 1'b0;
    bus.wdrop     = 1'b0;
    bus.req_ready = '0;
    bus.busy      = 1'b0;
    if (state_q == ST_BUSY) begin
      bus.wvalid             = bus.req_valid[grant_q];
      bus.wdata              = data_sel;
      bus.wlast              = bus.req_last[grant_q];
      bus.wdrop              = bus.req_drop[grant_q];
      bus.req_ready[grant_q] = bus.wready;
      bus.busy               = 1'b1;
    end
  end

  // Grant index, pointer and packet counter updates.
  always_comb begin
    grant_d   = grant_q;
    rr_d      = rr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (start_pkt) begin
      grant_d = sel_id;
    end else if (last_acc) begin
      grant_d = '0;
      rr_d    = ID_WIDTH'((32'(grant_q) + 32'd1) % N_REQ);
      if (pkt_cnt_q != {CNT_WIDTH{1'b1}}) begin
        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (src_srst) begin
      grant_q   <= '0;
      rr_q      <= '0;
      pkt_cnt_q <= '0;
    end else begin
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_hs_fifo_afifo_wr_arb.sv
// Randomized bench for hs_fifo_afifo_wr_arb against a packet-level arbitration model.
module tb_hs_fifo_afifo_wr_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic srst;

  hs_fifo_afifo_wr_arb_if #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  hs_fifo_afifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .src_clk  (clk),
    .src_srst (srst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Knobs shaping the random traffic (percent probabilities).
  int unsigned p_valid, p_ready, p_af, p_drop, p_rst, len_min, len_max;
  logic [N-1:0] en_mask;
  bit force_rst;

  // Requester-side packet state.
  bit          r_act  [N];
  int          r_beat [N];
  int          r_len  [N];
  bit          r_drop [N];
  logic [DW-1:0] r_data [N];

  // Reference model state.
  bit m_busy;
  int m_gid, m_rr, m_cnt;

  int obs_g[$];
  bit prev_busy;
  int rr_exp [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    logic [N-1:0]    v, l, d, e_rdy;
    logic [N*DW-1:0] dat;
    logic            wr, af, rs, e_valid, e_last, e_drop, acc, done;
    logic [DW-1:0]   e_data;
    int              idx;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!r_act[i] && ($urandom_range(99) < p_valid)) begin
        if (r_beat[i] == 0) begin
          r_len[i]  = int'($urandom_range(len_max, len_min));
          r_drop[i] = ($urandom_range(99) < p_drop);
        end
        r_act[i]  = 1'b1;
        r_data[i] = $urandom;
      end
      v[IW'(i)]        = r_act[i];
      l[IW'(i)]        = (r_beat[i] == r_len[i] - 1);
      d[IW'(i)]        = r_drop[i];
      dat[i*DW +: DW]  = r_data[i];
    end
    wr = ($urandom_range(99) < p_ready);
    af = ($urandom_range(99) < p_af);
    rs = force_rst || ($urandom_range(99) < p_rst);
    bus.req_valid    = v;
    bus.req_last     = l;
    bus.req_drop     = d;
    bus.req_data     = dat;
    bus.req_en       = en_mask;
    bus.wready       = wr;
    bus.walmost_full = af;
    srst             = rs;
    #1;
    e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_drop = 1'b0; e_rdy = '0;
    if (m_busy) begin
      e_valid          = v[IW'(m_gid)];
      e_data           = dat[m_gid*DW +: DW];
      e_last           = l[IW'(m_gid)];
      e_drop           = d[IW'(m_gid)];
      e_rdy[IW'(m_gid)] = wr;
    end
    check("busy",      64'(bus.busy),      64'(m_busy));
    check("grant_id",  64'(bus.grant_id),  64'(m_gid));
    check("wvalid",    64'(bus.wvalid),    64'(e_valid));
    check("wdata",     64'(bus.wdata),     64'(e_data));
    check("wlast",     64'(bus.wlast),     64'(e_last));
    check("wdrop",     64'(bus.wdrop),     64'(e_drop));
    check("req_ready", 64'(bus.req_ready), 64'(e_rdy));
    check("pkt_cnt",   64'(bus.pkt_cnt),   64'(m_cnt));
    if (bus.busy && !prev_busy) obs_g.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    // Advance requesters and model for the coming edge.
    acc  = m_busy && v[IW'(m_gid)] && wr;
    done = acc && l[IW'(m_gid)];
    if (acc) begin
      r_act[m_gid]  = 1'b0;
      r_beat[m_gid] = done ? 0 : r_beat[m_gid] + 1;
    end
    if (rs) begin
      m_busy = 1'b0; m_gid = 0; m_rr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (((v & en_mask) != '0) && !af) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!m_busy && v[IW'(idx)] && en_mask[IW'(idx)]) begin
            m_busy = 1'b1;
            m_gid  = idx;
          end
        end
      end
    end else if (done) begin
      m_busy = 1'b0;
      m_rr   = (m_gid + 1) % N;
      m_gid  = 0;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // Reset with quiet, freshly cleared requesters.
  task automatic rst_step();
    int unsigned pv;
    pv = p_valid;
    p_valid = 0;
    for (int i = 0; i < N; i++) begin
      r_act[i] = 1'b0; r_beat[i] = 0;
    end
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    p_valid = pv;
  endtask

  task automatic knobs(input int unsigned pv, input int unsigned pr, input int unsigned pa,
                       input int unsigned pd, input int unsigned pz, input int unsigned lmin,
                       input int unsigned lmax, input logic [N-1:0] en);
    p_valid = pv; p_ready = pr; p_af = pa; p_drop = pd; p_rst = pz;
    len_min = lmin; len_max = lmax; en_mask = en;
  endtask

  initial begin
    rr_exp = '{0, 1, 2, 3, 0};
    force_rst = 1'b0; prev_busy = 1'b0;
    m_busy = 1'b0; m_gid = 0; m_rr = 0; m_cnt = 0;
    knobs(0, 100, 0, 0, 0, 1, 1, 4'hF);
    bus.req_valid = '0; bus.req_last = '0; bus.req_drop = '0; bus.req_data = '0;
    bus.req_en = 4'hF; bus.wready = 1'b0; bus.walmost_full = 1'b0;
    srst = 1'b1;
    @(posedge clk);

    // Reset held, then idle with nothing offered.
    force_rst = 1'b1;
    repeat (3) step();
    force_rst = 1'b0;
    repeat (10) step();

    // Round-robin: everyone offers 2-beat packets continuously.
    obs_g.delete();
    knobs(100, 100, 0, 0, 0, 2, 2, 4'hF);
    repeat (16) step();
    check("rr_pkt_cnt", 64'(bus.pkt_cnt), 64'd5);
    check("rr_ngrants", 64'(obs_g.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < obs_g.size(); k++) check("rr_order", 64'(obs_g[k]), 64'(rr_exp[k]));

    // Back-pressure, then almost-full gating.
    knobs(60, 50, 0, 0, 0, 1, 5, 4'hF);
    repeat (300) step();
    knobs(70, 70, 40, 0, 0, 1, 4, 4'hF);
    repeat (300) step();

    // Enable mask 1010: only requesters 1 and 3, alternating.
    knobs(100, 100, 0, 0, 0, 1, 3, 4'b1010);
    rst_step();
    obs_g.delete();
    repeat (40) step();
    check("en_ngrants", 64'(obs_g.size() >= 8), 64'd1);
    for (int k = 0; k < obs_g.size(); k++) check("en_order", 64'(obs_g[k]), (k % 2 == 0) ? 64'd1 : 64'd3);

    // Dropped packets.
    knobs(70, 60, 10, 100, 0, 1, 4, 4'hF);
    repeat (150) step();
    knobs(70, 60, 10, 40, 0, 1, 4, 4'hF);
    repeat (150) step();

    // Random resets, then a directed reset on beat 2 of 5 of requester 1.
    knobs(70, 60, 10, 20, 5, 1, 5, 4'hF);
    repeat (300) step();
    knobs(100, 100, 0, 0, 0, 5, 5, 4'hF);
    rst_step();
    repeat (8) step();
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    step();
    check("rst_idle_busy", 64'(bus.busy), 64'd0);
    check("rst_idle_wvalid", 64'(bus.wvalid), 64'd0);
    step();
    check("rst_regrant_busy", 64'(bus.busy), 64'd1);
    check("rst_regrant_gid", 64'(bus.grant_id), 64'd0);

    // Counter saturation from 16'hFFFE.
    rst_step();
    force dut.pkt_cnt_q = 16'hFFFE;
    m_cnt = 65534;
    step();
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    knobs(100, 100, 0, 0, 0, 1, 2, 4'hF);
    repeat (60) step();
    check("sat_pkt_cnt", 64'(bus.pkt_cnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
